// File: rtl/xike_pkg.sv
// Shared constants and types for the xike frame parser and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xike_pkg;

    // Parser states: hunting for a header, timestamp halves, amplifier data, tail skip, locked header check
    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        TS_LO = 3'd1,
        TS_HI = 3'd2,
        DATA  = 3'd3,
        TAIL  = 3'd4,
        HDR   = 3'd5
    } xike_state_t;

    // Frame header, transmitted least-significant 16-bit word first
    localparam logic [63:0] RHYTHM_MAGIC = 64'hC691199927021942;

    // Frame geometry shared with spi_intan_interface_4_bank and the spike logic
    localparam int XIKE_NUM_STREAMS   = 8;   // 4 banks x 2 MISO lines
    localparam int XIKE_CH_PER_STREAM = 35;  // 3 aux + 32 amplifier
    localparam int XIKE_TAIL_WORDS    = 10;  // ADC, TTL, filler

endpackage

// File: rtl/xike_magic_matcher.sv
// Sliding 4-word magic header matcher shared by the hunt and locked-header-check phases.
// Latency: match_done/mismatch are combinational on the enabled word; hdr_idx updates on the next edge.
// Backpressure: none; i_en qualifies each word and holds hdr_idx when low.
module xike_magic_matcher
    import xike_pkg::*;
#(
    parameter logic [63:0] MAGIC = RHYTHM_MAGIC
)(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [15:0] i_word,
    output logic        o_match_done,
    output logic        o_mismatch
);

    logic [1:0]  r_hdr_idx;
    logic [15:0] w_expect;
    logic        w_hit;

    assign w_expect     = MAGIC[16*r_hdr_idx +: 16];
    assign w_hit        = (i_word == w_expect);
    assign o_match_done = i_en && w_hit && (r_hdr_idx == 2'd3);
    assign o_mismatch   = i_en && !w_hit;

    // Advance on a matching word (wrapping to 0 after the 4th); on a miss restart, keeping a fresh first word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hdr_idx <= 2'd0;
        end else if (i_en) begin
            if (w_hit) begin
                r_hdr_idx <= r_hdr_idx + 2'd1;
            end else begin
                r_hdr_idx <= (i_word == MAGIC[15:0]) ? 2'd1 : 2'd0;
            end
        end
    end

endmodule

// File: rtl/xike_frame_parser.sv
// Locks onto the magic header in the raw Intan word stream and emits tagged amplifier samples plus frame stats.
// Latency: every output is registered; strobes and sample fields appear 1 cycle after the causing word.
// Backpressure: none; one word per WEN cycle, sustained back-to-back, WEN=0 cycles hold all state.
module xike_frame_parser
    import xike_pkg::*;
#(
    parameter int          NUM_STREAMS   = XIKE_NUM_STREAMS,
    parameter int          CH_PER_STREAM = XIKE_CH_PER_STREAM,
    parameter int          TAIL_WORDS    = XIKE_TAIL_WORDS,
    parameter logic [63:0] MAGIC         = RHYTHM_MAGIC
)(
    input  logic                             spi_clk,
    input  logic                             reset_n,
    input  logic [15:0]                      FIFO_DATA_TO_XIKE,
    input  logic                             FIFO_DATA_TO_XIKE_WEN,
    output logic [15:0]                      sample_data,
    output logic [$clog2(NUM_STREAMS)-1:0]   sample_stream,
    output logic [$clog2(CH_PER_STREAM)-1:0] sample_ch,
    output logic                             sample_valid,
    output logic [31:0]                      timestamp,
    output logic                             frame_start,
    output logic                             frame_done,
    output logic                             locked,
    output logic                             ts_gap,
    output logic [15:0]                      frame_err_cnt,
    input  logic                             clr_stats
);

    localparam int SW = $clog2(NUM_STREAMS);
    localparam int CW = $clog2(CH_PER_STREAM);
    localparam int TW = (TAIL_WORDS > 1) ? $clog2(TAIL_WORDS) : 1;

    xike_state_t r_state;
    logic [15:0] r_ts_lo;
    logic        r_have_prev;   // a timestamp has been captured since the current lock began
    logic [SW-1:0] r_stream;
    logic [CW-1:0] r_ch;
    logic [TW-1:0] r_tail;

    logic        w_match_en;
    logic        w_match_done;
    logic        w_mismatch;
    logic [31:0] w_ts_new;
    logic        w_gap_base;
    logic [15:0] w_err_base;

    assign w_match_en = FIFO_DATA_TO_XIKE_WEN && ((r_state == HUNT) || (r_state == HDR));
    assign w_ts_new   = {FIFO_DATA_TO_XIKE, r_ts_lo};
    // Clear is applied first so a same-cycle error or gap still lands on top of it
    assign w_gap_base = clr_stats ? 1'b0  : ts_gap;
    assign w_err_base = clr_stats ? 16'h0 : frame_err_cnt;

    xike_magic_matcher #(
        .MAGIC        (MAGIC)
    ) u_matcher (
        .i_clk        (spi_clk),
        .i_rst_n      (reset_n),
        .i_en         (w_match_en),
        .i_word       (FIFO_DATA_TO_XIKE),
        .o_match_done (w_match_done),
        .o_mismatch   (w_mismatch)
    );

    // Frame FSM with registered sample, strobe and statistics outputs
    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= HUNT;
            r_ts_lo       <= '0;
            r_have_prev   <= 1'b0;
            r_stream      <= '0;
            r_ch          <= '0;
            r_tail        <= '0;
            sample_data   <= '0;
            sample_stream <= '0;
            sample_ch     <= '0;
            sample_valid  <= 1'b0;
            timestamp     <= '0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            locked        <= 1'b0;
            ts_gap        <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            sample_valid  <= 1'b0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            ts_gap        <= w_gap_base;
            frame_err_cnt <= w_err_base;
            if (FIFO_DATA_TO_XIKE_WEN) begin
                case (r_state)
                    HUNT: begin
                        if (w_match_done) begin
                            r_state <= TS_LO;
                            locked  <= 1'b1;
                        end
                    end
                    TS_LO: begin
                        r_ts_lo <= FIFO_DATA_TO_XIKE;
                        r_state <= TS_HI;
                    end
                    TS_HI: begin
                        timestamp   <= w_ts_new;
                        frame_start <= 1'b1;
                        if (r_have_prev && (w_ts_new != timestamp + 32'd1)) begin
                            ts_gap <= 1'b1;
                        end
                        r_have_prev <= 1'b1;
                        r_stream    <= '0;
                        r_ch        <= '0;
                        r_state     <= DATA;
                    end
                    DATA: begin
                        sample_data   <= FIFO_DATA_TO_XIKE;
                        sample_stream <= r_stream;
                        sample_ch     <= r_ch;
                        sample_valid  <= 1'b1;
                        if (r_stream == SW'(NUM_STREAMS - 1)) begin
                            r_stream <= '0;
                            if (r_ch == CW'(CH_PER_STREAM - 1)) begin
                                r_ch    <= '0;
                                r_tail  <= '0;
                                r_state <= (TAIL_WORDS == 0) ? HDR : TAIL;
                            end else begin
                                r_ch <= r_ch + 1'b1;
                            end
                        end else begin
                            r_stream <= r_stream + 1'b1;
                        end
                    end
                    TAIL: begin
                        if (r_tail == TW'(TAIL_WORDS - 1)) begin
                            frame_done <= 1'b1;
                            r_tail     <= '0;
                            r_state    <= HDR;
                        end else begin
                            r_tail <= r_tail + 1'b1;
                        end
                    end
                    HDR: begin
                        if (w_match_done) begin
                            r_state <= TS_LO;
                        end else if (w_mismatch) begin
                            // The matcher re-evaluates this word as a hunt candidate in the same cycle
                            frame_err_cnt <= (w_err_base == 16'hFFFF) ? w_err_base : w_err_base + 16'd1;
                            locked        <= 1'b0;
                            r_have_prev   <= 1'b0;
                            r_state       <= HUNT;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xike_frame_parser.sv
// Randomized scoreboard bench for xike_frame_parser against a frame-position reference model.
// Latency: expects each output event one cycle after the word that causes it.
// Backpressure: drives WEN back-to-back or with random idle gaps.
module tb_xike_frame_parser;

    localparam int NS    = 8;
    localparam int CH    = 35;
    localparam int TW    = 10;
    localparam int NDATA = NS * CH;
    localparam int FL    = 6 + NDATA + TW;
    localparam logic [63:0] MAGIC_C = 64'hC691199927021942;

    logic        spi_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] din     = 16'h0;
    logic        wen     = 1'b0;
    logic        clr     = 1'b0;

    logic [15:0] sample_data;
    logic [2:0]  sample_stream;
    logic [5:0]  sample_ch;
    logic        sample_valid;
    logic [31:0] timestamp;
    logic        frame_start;
    logic        frame_done;
    logic        locked;
    logic        ts_gap;
    logic [15:0] frame_err_cnt;

    xike_frame_parser dut (
        .spi_clk               (spi_clk),
        .reset_n               (reset_n),
        .FIFO_DATA_TO_XIKE     (din),
        .FIFO_DATA_TO_XIKE_WEN (wen),
        .sample_data           (sample_data),
        .sample_stream         (sample_stream),
        .sample_ch             (sample_ch),
        .sample_valid          (sample_valid),
        .timestamp             (timestamp),
        .frame_start           (frame_start),
        .frame_done            (frame_done),
        .locked                (locked),
        .ts_gap                (ts_gap),
        .frame_err_cnt         (frame_err_cnt),
        .clr_stats             (clr)
    );

    always #5 spi_clk = ~spi_clk;

    int n_checks  = 0;
    int n_err     = 0;
    int n_samples = 0;

    // Reference model: position within the frame, header history while hunting
    bit          m_locked    = 0;
    int          m_pos       = 0;
    logic [15:0] m_hist[$];
    logic [15:0] m_ts_lo     = 16'h0;
    logic [31:0] m_ts        = 32'h0;
    bit          m_have_prev = 0;
    bit          m_gap       = 0;
    int          m_err       = 0;

    logic [24:0] exp_smp[$];
    logic [31:0] exp_ts[$];
    int          exp_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_locked = 0; m_pos = 0; m_hist.delete(); m_ts_lo = 16'h0; m_ts = 32'h0;
        m_have_prev = 0; m_gap = 0; m_err = 0;
        exp_smp.delete(); exp_ts.delete(); exp_done = 0;
    endfunction

    function automatic void model_word(input logic [15:0] w, input bit c);
        logic [31:0] ts;
        logic [31:0] nxt;
        int k;
        if (c) begin
            m_err = 0;
            m_gap = 0;
        end
        if (!m_locked) begin
            m_hist.push_back(w);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
            if (m_hist.size() == 4 && {m_hist[3], m_hist[2], m_hist[1], m_hist[0]} == MAGIC_C) begin
                m_locked = 1;
                m_pos    = 4;
                m_hist.delete();
            end
        end else if (m_pos < 4) begin
            if (w == MAGIC_C[16*m_pos +: 16]) begin
                m_pos++;
            end else begin
                if (m_err < 65535) m_err++;
                m_locked    = 0;
                m_have_prev = 0;
                m_hist.delete();
                m_hist.push_back(w);
            end
        end else if (m_pos == 4) begin
            m_ts_lo = w;
            m_pos   = 5;
        end else if (m_pos == 5) begin
            ts  = {w, m_ts_lo};
            nxt = m_ts + 32'd1;
            if (m_have_prev && ts != nxt) m_gap = 1;
            m_ts        = ts;
            m_have_prev = 1;
            exp_ts.push_back(ts);
            m_pos = 6;
        end else if (m_pos < 6 + NDATA) begin
            k = m_pos - 6;
            exp_smp.push_back({w, 3'(k % NS), 6'(k / NS)});
            m_pos++;
        end else if (m_pos == FL - 1) begin
            exp_done++;
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endfunction

    logic [24:0] mon_e;
    logic [31:0] mon_ts;

    // Monitor: pop and compare whenever the DUT presents an output event
    always @(negedge spi_clk) begin
        if (reset_n) begin
            if (sample_valid) begin
                n_samples++;
                if (exp_smp.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_sample: actual data=0x%0h s=%0d ch=%0d required none",
                             sample_data, sample_stream, sample_ch);
                end else begin
                    mon_e = exp_smp.pop_front();
                    chk("sample", {39'h0, sample_data, sample_stream, sample_ch}, {39'h0, mon_e});
                end
            end
            if (frame_start) begin
                if (exp_ts.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_frame_start: actual ts=0x%0h required none", timestamp);
                end else begin
                    mon_ts = exp_ts.pop_front();
                    chk("frame_start_ts", {32'h0, timestamp}, {32'h0, mon_ts});
                end
            end
            if (frame_done) begin
                n_checks++;
                if (exp_done == 0) begin
                    n_err++;
                    $display("FAIL unexpected_frame_done: actual 1 required 0");
                end else begin
                    exp_done--;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge spi_clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] w, input bit gaps);
        int g = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1 && g < 6) begin
                idle(1);
                g++;
            end
        end
        din = w;
        wen = 1'b1;
        model_word(w, clr);
        @(posedge spi_clk);
        #1;
        wen = 1'b0;
        clr = 1'b0;
    endtask

    // corrupt: header word index to flip (-1 none); ndata: data words sent (NDATA = whole frame incl. tail)
    task automatic send_frame(input logic [31:0] ts, input int corrupt, input bit gaps,
                              input bit seq, input int ndata, input bit clr_on_corrupt);
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            w = MAGIC_C[16*i +: 16];
            if (i == corrupt) begin
                w   = w ^ 16'h0100;
                clr = clr_on_corrupt;
            end
            send(w, gaps);
        end
        send(ts[15:0], gaps);
        send(ts[31:16], gaps);
        for (int k = 0; k < ndata; k++) begin
            send(seq ? 16'(k) : 16'($urandom), gaps);
        end
        if (ndata == NDATA) begin
            for (int t = 0; t < TW; t++) send(16'($urandom), gaps);
        end
    endtask

    task automatic check_status(input string name);
        idle(2);
        chk({name, "_locked"}, {63'h0, locked}, {63'h0, m_locked});
        chk({name, "_ts_gap"}, {63'h0, ts_gap}, {63'h0, m_gap});
        chk({name, "_err_cnt"}, {48'h0, frame_err_cnt}, 64'(m_err));
        chk({name, "_timestamp"}, {32'h0, timestamp}, {32'h0, m_ts});
    endtask

    task automatic chk_zero(input string name);
        chk(name, {sample_data, sample_stream, sample_ch, sample_valid, frame_start, frame_done,
                   locked, ts_gap, 3'b0}, 64'h0);
        chk({name, "_ts_err"}, {16'h0, timestamp, frame_err_cnt}, 64'h0);
    endtask

    task automatic do_reset(input string name);
        reset_n = 1'b0;
        model_reset();
        idle(2);
        chk_zero(name);
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    int s0;
    logic [31:0] rts;

    initial begin
        idle(2);
        chk_zero("reset_state");
        reset_n = 1'b1;
        idle(1);

        // Clean frame with sequential data
        send_frame(32'h00010002, -1, 0, 1, NDATA, 0);
        check_status("clean");
        chk("clean_samples", 64'(n_samples), 64'(NDATA));
        chk("clean_locked_c", {63'h0, locked}, 64'h1);
        chk("clean_ts_c", {32'h0, timestamp}, 64'h00010002);

        // Garbage prefix before a frame
        do_reset("reset_before_garbage");
        send(16'h1942, 0);
        send_frame(32'h00000100, -1, 0, 0, NDATA, 0);
        check_status("garbage");
        chk("garbage_err_c", {48'h0, frame_err_cnt}, 64'h0);

        // Timestamp gap detection: 5, 6, 8
        do_reset("reset_before_gap");
        send_frame(32'd5, -1, 0, 0, NDATA, 0);
        send_frame(32'd6, -1, 0, 0, NDATA, 0);
        check_status("ts6");
        chk("ts6_gap_c", {63'h0, ts_gap}, 64'h0);
        send_frame(32'd8, -1, 0, 0, NDATA, 0);
        check_status("ts8");
        chk("ts8_gap_c", {63'h0, ts_gap}, 64'h1);

        // 32-bit timestamp wrap is not a gap
        do_reset("reset_before_wrap");
        send_frame(32'hFFFFFFFF, -1, 0, 0, NDATA, 0);
        send_frame(32'h00000000, -1, 0, 0, NDATA, 0);
        check_status("wrap");
        chk("wrap_gap_c", {63'h0, ts_gap}, 64'h0);

        // Corrupt 3rd header word, then relock
        send_frame(32'h00000001, -1, 0, 0, NDATA, 0);
        send_frame(32'h00000002, 2, 0, 0, NDATA, 0);
        check_status("corrupt");
        chk("corrupt_err_c", {48'h0, frame_err_cnt}, 64'h1);
        chk("corrupt_locked_c", {63'h0, locked}, 64'h0);
        send_frame(32'h00000064, -1, 0, 0, NDATA, 0);
        check_status("relock");

        // Clear and error on the same word: count restarts at 1
        send_frame(32'h00000065, 0, 0, 0, NDATA, 1);
        check_status("clr_err");
        chk("clr_err_cnt_c", {48'h0, frame_err_cnt}, 64'h1);
        send_frame(32'h00000200, -1, 0, 0, NDATA, 0);
        check_status("relock2");

        // Random WEN gaps with random timestamps
        for (int f = 0; f < 4; f++) begin
            rts = (f == 2) ? $urandom : m_ts + 32'd1;
            send_frame(rts, -1, 1, 0, NDATA, 0);
            check_status("gaps");
        end

        // Reset mid-frame at data word 100, then no samples until a full header
        send_frame(32'h00001000, -1, 1, 1, 100, 0);
        idle(1);
        do_reset("midframe_reset");
        s0 = n_samples;
        for (int k = 0; k < 50; k++) send(16'(k + 100), 1);
        idle(2);
        chk("post_reset_no_samples", 64'(n_samples), 64'(s0));
        send_frame(32'h00002000, -1, 1, 0, NDATA, 0);
        check_status("post_reset_frame");
        chk("post_reset_locked_c", {63'h0, locked}, 64'h1);

        idle(3);
        chk("smp_queue_empty", 64'(exp_smp.size()), 64'h0);
        chk("ts_queue_empty", 64'(exp_ts.size()), 64'h0);
        chk("done_pending", 64'(exp_done), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
